// File: rtl/imem_loader_pkg.sv
// Shared processor constants plus the instruction-loader state encoding.
// Loader states follow the byte-stream framing: 2-byte count header, then little-endian words.
package imem_loader_pkg;

    localparam int XLEN         = 32;
    localparam int RESET_VECTOR = 0;
    localparam int HDR_BYTES    = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } ldr_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs four stream bytes into one little-endian word; o_word already includes the byte being shifted in.
// Latency: combinational word/complete on the 4th byte; the caller holds i_shift low to stall.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    input  logic            i_shift,
    input  logic [7:0]      i_byte,
    output logic [XLEN-1:0] o_word,
    output logic            o_complete
);

    logic [XLEN-1:0] r_shift;
    logic [1:0]      r_idx;

    // First byte ends up in [7:0] after four right-shifts.
    assign o_word     = {i_byte, r_shift[XLEN-1:8]};
    assign o_complete = i_shift && (r_idx == 2'd3);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_shift) begin
            r_shift <= o_word;
            r_idx   <= r_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory and holds the core in reset until done.
// Latency: imem_we pulses the cycle after a word's 4th byte; s_valid may stall any receive state.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 128,
    parameter int AW         = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_rst,
    output logic          done,
    output logic          error
);

    ldr_state_t    r_state;
    ldr_state_t    w_next;
    logic [15:0]   r_count;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [15:0]   w_len;
    logic [31:0]   w_word;
    logic          w_clr;
    logic          w_shift;
    logic          w_complete;
    logic          w_last;

    assign w_len      = {s_data, r_count[7:0]};
    assign w_last     = (16'(r_addr) + 16'd1) == r_count;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;

    word_assembler u_asm (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_clr      (w_clr),
        .i_shift    (w_shift),
        .i_byte     (s_data),
        .o_word     (w_word),
        .o_complete (w_complete)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        s_ready  = 1'b0;
        imem_we  = 1'b0;
        core_rst = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        w_clr    = 1'b0;
        w_shift  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = LEN_LO;
            end
            LEN_LO: begin
                s_ready = 1'b1;
                if (s_valid) w_next = LEN_HI;
            end
            LEN_HI: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (w_len == 16'd0) begin
                        w_next = DONE;
                    end else if (w_len > 16'(IMEM_DEPTH)) begin
                        w_next = ERR;
                    end else begin
                        w_next = DATA;
                        w_clr  = 1'b1;
                    end
                end
            end
            DATA: begin
                s_ready = 1'b1;
                w_shift = s_valid;
                if (w_complete) w_next = WRITE;
            end
            WRITE: begin
                imem_we = 1'b1;
                w_next  = w_last ? DONE : DATA;
            end
            DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
                if (start) w_next = LEN_LO;
            end
            ERR: begin
                error = 1'b1;
                if (start) w_next = LEN_LO;
            end
            default: w_next = IDLE;
        endcase
    end

    // Write address/data are registered so they stay put between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (r_state == LEN_LO && s_valid) r_count[7:0]  <= s_data;
            if (r_state == LEN_HI && s_valid) r_count[15:8] <= s_data;
            if (w_clr) begin
                r_addr <= '0;
            end else if (imem_we && !w_last) begin
                r_addr <= r_addr + AW'(1);
            end
            if (w_complete) r_wdata <= w_word;
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 128: instruction memory depth in 32-bit words.
REQ-002 Parameter AW, default 7: word address width, equal to clog2(IMEM_DEPTH).
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: the reset is asynchronous and active-low (low = reset).
REQ-005 Port start, input, 1: single-cycle pulse that begins a load session.
REQ-006 Port s_valid, input, 1: a byte is present on s_data.
REQ-007 Port s_data, input, 8: program byte stream.
REQ-008 Port s_ready, output, 1: the loader accepts the byte; transfer occurs when s_valid and s_ready are both high.
REQ-009 Port imem_we, output, 1: one-cycle instruction memory write strobe.
REQ-010 Port imem_addr, output, AW: word address of the write.
REQ-011 Port imem_wdata, output, 32: instruction word to write.
REQ-012 Port core_rst, output, 1: active-high reset to the processor core; asserted whenever a load is not complete.
REQ-013 Port done, output, 1: level; the load completed successfully.
REQ-014 Port error, output, 1: level; the header word count exceeded IMEM_DEPTH.

Function
REQ-015 The FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE and ERR.
REQ-016 Stream format: a 16-bit word count N, low byte first; then 4*N bytes; each word is little-endian (first byte goes to bits [7:0]).
REQ-017 IDLE: s_ready=0, core_rst=1. A start pulse moves the FSM to LEN_LO.
REQ-018 LEN_LO: s_ready=1. A transfer latches count[7:0] and moves the FSM to LEN_HI.
REQ-019 LEN_HI: s_ready=1. A transfer latches count[15:8], then branches:
- N=0: go to DONE.
- N>IMEM_DEPTH: go to ERR.
- Otherwise: go to DATA with the byte index and word address cleared.
REQ-020 DATA: s_ready=1. Each transfer shifts the byte into the word assembler. On the 4th byte the FSM moves to WRITE.
REQ-021 WRITE: lasts exactly one cycle with s_ready=0 and imem_we=1.
- imem_addr is the current word index and imem_wdata is the assembled word.
- Next state: DONE if this was word N-1, otherwise DATA with the address incremented.
REQ-022 Latency: imem_we SHALL pulse in the cycle immediately after the 4th byte of a word is accepted.
REQ-023 Backpressure: s_valid may drop in any receive state; the FSM holds state and the partial word without loss.
REQ-024 DONE: core_rst=0, done=1, s_ready=0.
REQ-025 ERR: core_rst=1, error=1, s_ready=0, and no imem writes occur.
REQ-026 A start pulse in DONE or ERR SHALL do all of the following on the next edge:
- Clear done and error.
- Reassert core_rst.
- Enter LEN_LO.
REQ-027 A start pulse in any other state SHALL be ignored.
REQ-028 Address arithmetic is AW bits wide and never wraps, because N is at most IMEM_DEPTH; the count compare uses the full 16 bits.
REQ-029 imem_we SHALL never be high outside WRITE. imem_addr and imem_wdata are don't-care when imem_we=0 but SHALL be held stable.

Reset
REQ-030 While rst is low the loader SHALL enter IDLE asynchronously.
REQ-031 Reset values: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, error=0, with all counters cleared.
REQ-032 Reset mid-load SHALL abandon the session. Words already written stay in memory, and no further write strobe is issued.

Structure
REQ-033 The FSM state encoding and the header length (2 bytes) SHALL live in the shared processor package alongside the existing core constants.
REQ-034 One sub-module, word_assembler, SHALL provide:
- A byte shift register and a 2-bit byte index.
- A word-complete flag.
- Clearing under FSM control.
REQ-035 The top level SHALL instantiate imem_loader ahead of the core. Its imem write port drives the instruction memory, and core_rst ORs into the core reset.

Verification
REQ-036 Bench 1 (nominal): send N=3 with words 0x00500093, 0x00A00113, 0x022081B3 back-to-back.
- Expect writes at addresses 0, 1 and 2 with those values.
- Expect done=1 and core_rst=0 after the third write.
REQ-037 Bench 2 (backpressure): same stream with s_valid toggling randomly.
- Expect identical writes.
- Expect s_ready=0 during each WRITE cycle.
REQ-038 Bench 3 (N=0): header 0x00,0x00.
- Expect DONE the cycle after the second byte, with no imem_we.
REQ-039 Bench 4 (oversize): N=129 with IMEM_DEPTH=128.
- Expect error=1, core_rst=1 and no writes.
- A start pulse then clears error and returns the FSM to LEN_LO.
REQ-040 Bench 5 (reset mid-load): assert rst low after the 6th byte.
- Expect immediate IDLE with reset values.
- Expect no further imem_we until a new start.
REQ-041 Bench 6 (restart): a start pulse in DONE followed by N=1, word 0xDEADBEEF.
- Expect core_rst reasserted, a write at address 0, then done.
